max_pool_controller: RTL and testbench
======================================

# max_pool_controller

Sequencing controller for the max-pool stage of the CNN datapath. It walks a buffered INPUT_DIM_HEIGHT×INPUT_DIM_WIDTH feature map window by window (STRIDE×STRIDE windows, stride STRIDE). In the forward pass it writes each window's signed maximum to the output buffer and records the winning position. In the backward pass it scatters each output-gradient element back to the recorded position in the input-gradient buffer and writes zero everywhere else. It sits between the layer's feature/gradient buffers and the rest of the layer pipeline, and is started by the network-level scheduler.

## Interface
Parameters:
- WIDTH, 16, data width (signed fixed-point)
- STRIDE, 2, window edge and stride; window holds WIN = STRIDE*STRIDE elements
- INPUT_DIM_WIDTH, 4, input map columns
- INPUT_DIM_HEIGHT, 4, input map rows
- OUTPUT_DIM_WIDTH, INPUT_DIM_WIDTH/STRIDE, output columns
- OUTPUT_DIM_HEIGHT, INPUT_DIM_HEIGHT/STRIDE, output rows

Ports (IA = $clog2(IN_H*IN_W), OA = $clog2(OUT_H*OUT_W), minimum 1):
- Clocking: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  asynchronous active-high reset
- Control:
  - start  in  1  begin a pass; sampled only in IDLE
  - mode  in  1  0 = forward, 1 = backward; sampled with start
  - busy  out  1  high whenever state ≠ IDLE
  - done  out  1  one-cycle pulse at pass end
- Input feature map read port:
  - in_rd_en  out  1  feature-map read strobe
  - in_rd_addr  out  IA  row-major feature-map address
  - in_rd_data  in  WIDTH  signed; valid the cycle after in_rd_en
- Pooled output write port:
  - out_wr_en  out  1  pooled-output write strobe
  - out_wr_addr  out  OA  row-major output address
  - out_wr_data  out  WIDTH  pooled maximum
- Output-gradient read port:
  - grad_rd_en  out  1  output-gradient read strobe
  - grad_rd_addr  out  OA  output-gradient address
  - grad_rd_data  in  WIDTH  valid the cycle after grad_rd_en
- Input-gradient write port:
  - gin_wr_en  out  1  input-gradient write strobe
  - gin_wr_addr  out  IA  input-gradient address
  - gin_wr_data  out  WIDTH  scattered gradient or zero

## Operation
- States: IDLE, FWD_READ, FWD_WRITE, BWD_READ, BWD_SCATTER, DONE.
- IDLE:
  - start=1 with mode=0 → FWD_READ; start=1 with mode=1 → BWD_READ.
  - Window counters and element counter k are cleared on entry.
- Window order: raster over (oy, ox). Element order within a window: k = dy*STRIDE + dx, row-major. Element address = (oy*STRIDE+dy)*IN_W + ox*STRIDE + dx.
- FWD_READ (WIN cycles): issue in_rd_en for element k on cycle k.
  - Data for element k-1 is compared on cycle k against the running max/argmax.
  - Element 0 initialises the running max unconditionally.
  - Compare is signed and uses strict >, so ties keep the earliest element in raster order.
- FWD_WRITE (1 cycle): fold the last element's data into the running max.
  - Assert out_wr_en with out_wr_addr = oy*OUT_W + ox and out_wr_data = final max.
  - Store the final argmax (log2(WIN) bits) in the internal argmax array at the same index.
  - Next state: FWD_READ for the next window, or DONE after the last window.
- BWD_READ (1 cycle): assert grad_rd_en at the output index.
- BWD_SCATTER (WIN cycles): on cycle k assert gin_wr_en at element k's address.
  - gin_wr_data = captured gradient if k == argmax[index], else 0.
  - The gradient is captured on scatter cycle 0 and held for the window.
  - Next state: BWD_READ or DONE.
- DONE: done=1 for one cycle → IDLE.
- start while busy is ignored, and so is a mode change mid-pass.
- Argmax array persists across passes. It is cleared to 0 only by reset, so a backward pass with no prior forward pass routes each gradient to element 0.
- All strobes are mutually exclusive. Addresses and data are 0 whenever their strobe is low.

## Timing
- Reset (asynchronous, any state): state=IDLE, all outputs 0, counters 0, argmax array 0. The next start after reset release begins a clean pass.
- start sampled on edge E; the first read strobe is high in the cycle after E.
- Forward pass: WIN+1 cycles per window. Backward pass: 1+WIN cycles per window.
- done is asserted the cycle after the final write. Total busy cycles = OUT_H*OUT_W*(WIN+1) + 1 (DONE included).
- Default parameters: 4 windows × 5 cycles + 1 = 21 busy cycles per pass.
- A new start is accepted in IDLE the cycle after DONE.

## Structure
- Package maxpool_pkg holds:
  - state enum maxpool_state_e
  - mode constants MP_FWD / MP_BWD
  - helper functions for WIN and index widths
- Sub-module max_pool_argmax_unit holds the running signed max/argmax register with init, update and strict-greater compare. The controller instantiates one.

## Test plan
- 2×2 map, STRIDE 2, map [1,3;2,4], forward → one write, out_wr_addr=0, data=4, stored argmax=3; done in cycle 6 after start edge.
- Same setup, then backward with gradient 8 → gin writes addr0..3 = 0,0,0,8; grad_rd_addr=0.
- 4×4 map with negatives (all windows ≤ 0, e.g. [-5,-2;-9,-2]) → per-window max -2; argmax is the first -2 (k=1), confirming signed compare and tie-break.
- 4×4 forward then backward with gradients 1,2,3,4 → exactly 16 gin writes, 4 non-zero, at the forward argmax addresses.
- start asserted during a busy pass and mode toggled mid-pass → no effect; strobe count unchanged; single done.
- rst raised mid forward pass (after the second window) → outputs 0 immediately; a following backward pass writes every gradient to element 0 of its window.

Source files
------------

// File: rtl/maxpool_pkg.sv
// ----------------------------------------------------------------------------
// | Module   : maxpool_pkg                                                    |
// | Brief    : Shared types and sizing helpers for the max-pool controller.   |
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

package maxpool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FWD_READ    = 3'd1,
        ST_FWD_WRITE   = 3'd2,
        ST_BWD_READ    = 3'd3,
        ST_BWD_SCATTER = 3'd4,
        ST_DONE        = 3'd5
    } maxpool_state_e;

    localparam logic MP_FWD = 1'b0;
    localparam logic MP_BWD = 1'b1;

    function automatic int win_f(input int stride);
        return stride * stride;
    endfunction

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/max_pool_argmax_unit.sv
// ----------------------------------------------------------------------------
// | Module   : max_pool_argmax_unit                                           |
// | Brief    : Running signed max/argmax with strict-greater compare.         |
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module max_pool_argmax_unit #(
    parameter int WIDTH = 16,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_init,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AW-1:0]    i_idx,
    output logic [WIDTH-1:0] o_max,
    output logic [AW-1:0]    o_arg
);

    logic [WIDTH-1:0] r_max;
    logic [AW-1:0]    r_arg;
    logic             w_take;

    // Strict > keeps the earliest element on ties.
    assign w_take = i_init || ($signed(i_data) > $signed(r_max));
    assign o_max  = w_take ? i_data : r_max;
    assign o_arg  = w_take ? i_idx  : r_arg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max <= '0;
            r_arg <= '0;
        end else if (i_en) begin
            r_max <= o_max;
            r_arg <= o_arg;
        end
    end

endmodule

`default_nettype wire

// File: rtl/max_pool_controller.sv
// ----------------------------------------------------------------------------
// | Module   : max_pool_controller                                            |
// | Brief    : Forward max-pool and backward gradient scatter sequencer.      |
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module max_pool_controller
    import maxpool_pkg::*;
#(
    parameter int WIDTH             = 16,
    parameter int STRIDE            = 2,
    parameter int INPUT_DIM_WIDTH   = 4,
    parameter int INPUT_DIM_HEIGHT  = 4,
    parameter int OUTPUT_DIM_WIDTH  = INPUT_DIM_WIDTH / STRIDE,
    parameter int OUTPUT_DIM_HEIGHT = INPUT_DIM_HEIGHT / STRIDE
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mode,
    output logic busy,
    output logic done,
    output logic in_rd_en,
    output logic [idx_w_f(INPUT_DIM_HEIGHT*INPUT_DIM_WIDTH)-1:0] in_rd_addr,
    input  logic [WIDTH-1:0] in_rd_data,
    output logic out_wr_en,
    output logic [idx_w_f(OUTPUT_DIM_HEIGHT*OUTPUT_DIM_WIDTH)-1:0] out_wr_addr,
    output logic [WIDTH-1:0] out_wr_data,
    output logic grad_rd_en,
    output logic [idx_w_f(OUTPUT_DIM_HEIGHT*OUTPUT_DIM_WIDTH)-1:0] grad_rd_addr,
    input  logic [WIDTH-1:0] grad_rd_data,
    output logic gin_wr_en,
    output logic [idx_w_f(INPUT_DIM_HEIGHT*INPUT_DIM_WIDTH)-1:0] gin_wr_addr,
    output logic [WIDTH-1:0] gin_wr_data
);

    localparam int c_WIN = win_f(STRIDE);
    localparam int c_IA  = idx_w_f(INPUT_DIM_HEIGHT * INPUT_DIM_WIDTH);
    localparam int c_OA  = idx_w_f(OUTPUT_DIM_HEIGHT * OUTPUT_DIM_WIDTH);
    localparam int c_KW  = idx_w_f(c_WIN);
    localparam int c_XW  = idx_w_f(OUTPUT_DIM_WIDTH);
    localparam int c_YW  = idx_w_f(OUTPUT_DIM_HEIGHT);

    maxpool_state_e   r_state;
    logic [c_KW-1:0]  r_k;
    logic [c_XW-1:0]  r_ox;
    logic [c_YW-1:0]  r_oy;
    logic             r_dv;
    logic [c_KW-1:0]  r_didx;
    logic [WIDTH-1:0] r_grad;
    logic [c_KW-1:0]  r_argmax [2**c_OA];

    logic             w_last_k;
    logic             w_last_col;
    logic             w_last_win;
    logic [c_XW-1:0]  w_nx_ox;
    logic [c_YW-1:0]  w_nx_oy;
    logic [c_OA-1:0]  w_idx;
    logic [WIDTH-1:0] w_fold_max;
    logic [c_KW-1:0]  w_fold_arg;

    function automatic logic [c_IA-1:0] elem_addr(input logic [c_YW-1:0] oy,
                                                   input logic [c_XW-1:0] ox,
                                                   input logic [c_KW-1:0] k);
        int a;
        a = (int'(oy) * STRIDE + int'(k) / STRIDE) * INPUT_DIM_WIDTH
          + int'(ox) * STRIDE + int'(k) % STRIDE;
        return c_IA'(a);
    endfunction

    function automatic logic [c_OA-1:0] out_idx(input logic [c_YW-1:0] oy,
                                                input logic [c_XW-1:0] ox);
        return c_OA'(int'(oy) * OUTPUT_DIM_WIDTH + int'(ox));
    endfunction

    assign w_last_k   = (r_k == c_KW'(c_WIN - 1));
    assign w_last_col = (r_ox == c_XW'(OUTPUT_DIM_WIDTH - 1));
    assign w_last_win = w_last_col && (r_oy == c_YW'(OUTPUT_DIM_HEIGHT - 1));
    assign w_nx_ox    = w_last_col ? '0 : r_ox + 1'b1;
    assign w_nx_oy    = w_last_col ? r_oy + 1'b1 : r_oy;
    assign w_idx      = out_idx(r_oy, r_ox);

    // Read data lags the strobe by one cycle, so the compare tracks a delayed index.
    max_pool_argmax_unit #(
        .WIDTH (WIDTH),
        .AW    (c_KW)
    ) u_argmax (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_dv),
        .i_init (r_didx == '0),
        .i_data (in_rd_data),
        .i_idx  (r_didx),
        .o_max  (w_fold_max),
        .o_arg  (w_fold_arg)
    );

    assign out_wr_data = out_wr_en ? w_fold_max : '0;
    assign gin_wr_data = (gin_wr_en && (r_k == r_argmax[w_idx]))
                       ? ((r_k == '0) ? grad_rd_data : r_grad) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
            r_dv         <= 1'b0;
            r_didx       <= '0;
            r_grad       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            in_rd_en     <= 1'b0;
            in_rd_addr   <= '0;
            out_wr_en    <= 1'b0;
            out_wr_addr  <= '0;
            grad_rd_en   <= 1'b0;
            grad_rd_addr <= '0;
            gin_wr_en    <= 1'b0;
            gin_wr_addr  <= '0;
            for (int i = 0; i < 2**c_OA; i++) r_argmax[i] <= '0;
        end else begin
            r_dv   <= in_rd_en;
            r_didx <= r_k;
            case (r_state)
                ST_IDLE: begin
                    r_k  <= '0;
                    r_ox <= '0;
                    r_oy <= '0;
                    if (start) begin
                        busy <= 1'b1;
                        if (mode == MP_FWD) begin
                            r_state    <= ST_FWD_READ;
                            in_rd_en   <= 1'b1;
                            in_rd_addr <= '0;
                        end else begin
                            r_state      <= ST_BWD_READ;
                            grad_rd_en   <= 1'b1;
                            grad_rd_addr <= '0;
                        end
                    end
                end
                ST_FWD_READ: begin
                    if (w_last_k) begin
                        r_state     <= ST_FWD_WRITE;
                        in_rd_en    <= 1'b0;
                        in_rd_addr  <= '0;
                        out_wr_en   <= 1'b1;
                        out_wr_addr <= w_idx;
                    end else begin
                        r_k        <= r_k + 1'b1;
                        in_rd_addr <= elem_addr(r_oy, r_ox, r_k + 1'b1);
                    end
                end
                ST_FWD_WRITE: begin
                    r_argmax[w_idx] <= w_fold_arg;
                    out_wr_en       <= 1'b0;
                    out_wr_addr     <= '0;
                    r_k             <= '0;
                    if (w_last_win) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state    <= ST_FWD_READ;
                        r_ox       <= w_nx_ox;
                        r_oy       <= w_nx_oy;
                        in_rd_en   <= 1'b1;
                        in_rd_addr <= elem_addr(w_nx_oy, w_nx_ox, '0);
                    end
                end
                ST_BWD_READ: begin
                    r_state      <= ST_BWD_SCATTER;
                    grad_rd_en   <= 1'b0;
                    grad_rd_addr <= '0;
                    r_k          <= '0;
                    gin_wr_en    <= 1'b1;
                    gin_wr_addr  <= elem_addr(r_oy, r_ox, '0);
                end
                ST_BWD_SCATTER: begin
                    if (r_k == '0) r_grad <= grad_rd_data;
                    if (w_last_k) begin
                        gin_wr_en   <= 1'b0;
                        gin_wr_addr <= '0;
                        r_k         <= '0;
                        if (w_last_win) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state      <= ST_BWD_READ;
                            r_ox         <= w_nx_ox;
                            r_oy         <= w_nx_oy;
                            grad_rd_en   <= 1'b1;
                            grad_rd_addr <= out_idx(w_nx_oy, w_nx_ox);
                        end
                    end else begin
                        r_k         <= r_k + 1'b1;
                        gin_wr_addr <= elem_addr(r_oy, r_ox, r_k + 1'b1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_max_pool_controller.sv
// ----------------------------------------------------------------------------
// | Module   : tb_max_pool_controller                                         |
// | Brief    : Scoreboard bench for the 4x4, stride-2 max-pool controller.    |
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_max_pool_controller;

    localparam int c_RD_IN  = 0;
    localparam int c_WR_OUT = 1;
    localparam int c_RD_GR  = 2;
    localparam int c_WR_GIN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic        busy, done;
    logic        in_rd_en, out_wr_en, grad_rd_en, gin_wr_en;
    logic [3:0]  in_rd_addr, gin_wr_addr;
    logic [1:0]  out_wr_addr, grad_rd_addr;
    logic [15:0] in_rd_data, out_wr_data, grad_rd_data, gin_wr_data;

    typedef struct {
        int kind;
        int addr;
        int data;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [15:0] fmap [16];
    logic [15:0] gmem [4];

    // Window raster order of input addresses for a 4x4 map, stride 2.
    int tbl  [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int fin  [16] = '{1, 3, -4, 7, 2, 4, 7, 0, -5, -2, 0, 0, -9, -2, 0, 0};
    int fmax [4]  = '{4, 7, -2, 0};
    int farg [4]  = '{3, 1, 1, 0};
    int zarg [4]  = '{0, 0, 0, 0};

    max_pool_controller dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .busy         (busy),
        .done         (done),
        .in_rd_en     (in_rd_en),
        .in_rd_addr   (in_rd_addr),
        .in_rd_data   (in_rd_data),
        .out_wr_en    (out_wr_en),
        .out_wr_addr  (out_wr_addr),
        .out_wr_data  (out_wr_data),
        .grad_rd_en   (grad_rd_en),
        .grad_rd_addr (grad_rd_addr),
        .grad_rd_data (grad_rd_data),
        .gin_wr_en    (gin_wr_en),
        .gin_wr_addr  (gin_wr_addr),
        .gin_wr_data  (gin_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        in_rd_data   <= in_rd_en   ? fmap[in_rd_addr]   : 16'h0;
        grad_rd_data <= grad_rd_en ? gmem[grad_rd_addr] : 16'h0;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int outs_nonzero();
        return int'(busy | done | in_rd_en | out_wr_en | grad_rd_en | gin_wr_en
                    | (|in_rd_addr) | (|out_wr_addr) | (|out_wr_data)
                    | (|grad_rd_addr) | (|gin_wr_addr) | (|gin_wr_data));
    endfunction

    always @(negedge clk) begin
        int   ns, kind, addr, data, leak;
        exp_t e;
        if (!rst) begin
            ns = int'(in_rd_en) + int'(out_wr_en) + int'(grad_rd_en) + int'(gin_wr_en);
            chk("strobe_exclusive", int'(ns > 1), 0);
            leak = 0;
            if (!in_rd_en && in_rd_addr != 0) leak = 1;
            if (!out_wr_en && (out_wr_addr != 0 || out_wr_data != 0)) leak = 1;
            if (!grad_rd_en && grad_rd_addr != 0) leak = 1;
            if (!gin_wr_en && (gin_wr_addr != 0 || gin_wr_data != 0)) leak = 1;
            chk("idle_bus_zero", leak, 0);
            if (ns == 1) begin
                kind = 0; addr = 0; data = 0;
                if (in_rd_en)   begin kind = c_RD_IN;  addr = int'(in_rd_addr); end
                if (out_wr_en)  begin kind = c_WR_OUT; addr = int'(out_wr_addr);
                                      data = int'($signed(out_wr_data)); end
                if (grad_rd_en) begin kind = c_RD_GR;  addr = int'(grad_rd_addr); end
                if (gin_wr_en)  begin kind = c_WR_GIN; addr = int'(gin_wr_addr);
                                      data = int'($signed(gin_wr_data)); end
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe_kind", kind, -1);
                end else begin
                    e = sbq.pop_front();
                    chk("strobe_kind", kind, e.kind);
                    chk("strobe_addr", addr, e.addr);
                    chk("strobe_data", data, e.data);
                end
            end
        end
    end

    task automatic push(input int kind, input int addr, input int data);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        sbq.push_back(e);
    endtask

    task automatic push_fwd(input int nwin);
        for (int w = 0; w < nwin; w++) begin
            for (int k = 0; k < 4; k++) push(c_RD_IN, tbl[w*4+k], 0);
            push(c_WR_OUT, w, fmax[w]);
        end
    endtask

    task automatic push_bwd(input int arg [4]);
        for (int w = 0; w < 4; w++) begin
            push(c_RD_GR, w, 0);
            for (int k = 0; k < 4; k++)
                push(c_WR_GIN, tbl[w*4+k], (k == arg[w]) ? int'($signed(gmem[w])) : 0);
        end
    endtask

    task automatic run_pass(input logic m, input int glitch, input int abort_at);
        int cyc, got, busyc;
        logic win;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; got = 0; busyc = 0;
        while (cyc <= 40 && got == 0) begin
            busyc += int'(busy);
            if (done) begin
                got = cyc;
            end else begin
                if (abort_at == cyc) begin
                    @(posedge clk);
                    #1 rst = 1'b1;
                    #1 chk("async_reset_outs", outs_nonzero(), 0);
                    @(negedge clk);
                    rst = 1'b0;
                    chk("abort_sb_drain", sbq.size(), 0);
                    return;
                end
                win   = (glitch != 0) && cyc >= 3 && cyc <= 8;
                start = win;
                mode  = win ? ~m : m;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        mode  = m;
        chk("done_cycle", got, 21);
        chk("busy_cycles", busyc, 21);
        @(negedge clk);
        chk("post_done_idle", int'({busy, done}), 0);
        chk("sb_drain", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        for (int i = 0; i < 16; i++) fmap[i] = 16'(fin[i]);
        for (int i = 0; i < 4; i++) gmem[i] = 16'(i + 1);
        repeat (2) @(negedge clk);
        chk("reset_outs", outs_nonzero(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", outs_nonzero(), 0);

        // Forward: mixed signs, ties, all-negative window, all-zero window.
        push_fwd(4);
        run_pass(1'b0, 0, 0);

        // Backward with gradients 1..4 routed to the forward argmax.
        push_bwd(farg);
        run_pass(1'b1, 0, 0);

        // Forward again with start and mode disturbed mid-pass.
        push_fwd(4);
        run_pass(1'b0, 1, 0);

        // Reset after the second window clears the argmax memory.
        push_fwd(2);
        run_pass(1'b0, 0, 10);

        for (int i = 0; i < 4; i++) gmem[i] = 16'(i + 5);
        push_bwd(zarg);
        run_pass(1'b1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
